// File: rtl/rggen_rr_arbiter_if.sv
// rggen_rr_arbiter_if: upstream request/response and downstream access signals of the round-robin arbiter
interface rggen_rr_arbiter_if #(
  parameter int REQUESTERS     = 2,
  parameter int PAYLOAD_WIDTH  = 32,
  parameter int RESPONSE_WIDTH = 34
);
  logic [REQUESTERS-1:0]               i_request_valid;
  logic [REQUESTERS*PAYLOAD_WIDTH-1:0] i_request_payload;
  logic [REQUESTERS-1:0]               o_request_ready;
  logic [RESPONSE_WIDTH-1:0]           o_response;
  logic [REQUESTERS-1:0]               o_grant;
  logic                                o_valid;
  logic [PAYLOAD_WIDTH-1:0]            o_payload;
  logic                                i_ready;
  logic [RESPONSE_WIDTH-1:0]           i_response;
  modport slave (
    input  i_request_valid, i_request_payload, i_ready, i_response,
    output o_request_ready, o_response, o_grant, o_valid, o_payload
  );
  modport master (
    output i_request_valid, i_request_payload, i_ready, i_response,
    input  o_request_ready, o_response, o_grant, o_valid, o_payload
  );
endinterface

// File: rtl/rggen_rr_arbiter.sv
// rggen_rr_arbiter: round-robin arbiter steering one of REQUESTERS payloads onto a shared downstream port
module rggen_rr_arbiter #(
  parameter int REQUESTERS     = 2,
  parameter int PAYLOAD_WIDTH  = 32,
  parameter int RESPONSE_WIDTH = 34
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  rggen_rr_arbiter_if.slave   bus
);
  localparam int IW = REQUESTERS > 1 ? $clog2(REQUESTERS) : 1;
  localparam logic [IW-1:0] LAST_INIT = IW'(REQUESTERS - 1);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e                state_q, state_d;
  logic [REQUESTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         win_idx, gnt_idx;
  logic                  win_found;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_INIT;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end
  // search starts just after the last completed winner and wraps
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    gnt_idx   = '0;
    for (int k = 1; k <= REQUESTERS; k++) begin
      if (!win_found && bus.i_request_valid[IW'((int'(last_q) + k) % REQUESTERS)]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(last_q) + k) % REQUESTERS);
      end
    end
    for (int i = 0; i < REQUESTERS; i++) begin
      if (grant_q[i]) gnt_idx = IW'(i);
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (state_q == IDLE && win_found) begin
      state_d          = BUSY;
      grant_d          = '0;
      grant_d[win_idx] = 1'b1;
    end else if (state_q == BUSY && bus.i_ready) begin
      state_d = IDLE;
      grant_d = '0;
      last_d  = gnt_idx;
    end
  end
  always_comb begin
    bus.o_valid         = state_q == BUSY;
    bus.o_grant         = grant_q;
    bus.o_request_ready = grant_q & {REQUESTERS{bus.i_ready}};
    bus.o_response      = bus.i_response;
    bus.o_payload       = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      bus.o_payload = bus.o_payload | ({PAYLOAD_WIDTH{grant_q[i]}} & bus.i_request_payload[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]);
    end
  end
endmodule

// File: tb/tb_rggen_rr_arbiter.sv
// tb_rggen_rr_arbiter: directed vector table plus hand sequences for long transactions and async reset
module tb_rggen_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  rggen_rr_arbiter_if #(.REQUESTERS(4), .PAYLOAD_WIDTH(32), .RESPONSE_WIDTH(34)) bus ();
  rggen_rr_arbiter #(.REQUESTERS(4), .PAYLOAD_WIDTH(32), .RESPONSE_WIDTH(34)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  valid;
    logic        ready;
    logic [33:0] resp;
    logic [3:0]  grant;
    logic [3:0]  rr;
  } vec_t;
  vec_t tbl [22];
  function automatic logic [31:0] exp_pay(input logic [3:0] g);
    case (g)
      4'b0001: return 32'hA5A5_0000;
      4'b0010: return 32'hA5A5_0001;
      4'b0100: return 32'hA5A5_0002;
      4'b1000: return 32'hA5A5_0003;
      default: return 32'h0;
    endcase
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] rr);
    check({tag, " grant"}, 64'(bus.o_grant), 64'(g));
    check({tag, " valid"}, 64'(bus.o_valid), 64'(|g));
    check({tag, " payload"}, 64'(bus.o_payload), 64'(exp_pay(g)));
    check({tag, " req_ready"}, 64'(bus.o_request_ready), 64'(rr));
  endtask
  task automatic cyc(input logic [3:0] v, input logic r, input logic [33:0] resp);
    @(posedge clk);
    #1;
    bus.i_request_valid = v;
    bus.i_ready         = r;
    bus.i_response      = resp;
    #1;
  endtask
  initial begin
    tbl = '{
      '{4'b1111, 1'b1, 34'h0_0000_0011, 4'b0000, 4'b0000},
      '{4'b1111, 1'b1, 34'h0_0000_0012, 4'b0001, 4'b0001},
      '{4'b1111, 1'b1, 34'h0_0000_0013, 4'b0000, 4'b0000},
      '{4'b1111, 1'b1, 34'h0_0000_0014, 4'b0010, 4'b0010},
      '{4'b1111, 1'b1, 34'h0_0000_0015, 4'b0000, 4'b0000},
      '{4'b1111, 1'b1, 34'h0_0000_0016, 4'b0100, 4'b0100},
      '{4'b1111, 1'b1, 34'h0_0000_0017, 4'b0000, 4'b0000},
      '{4'b1111, 1'b1, 34'h0_0000_0018, 4'b1000, 4'b1000},
      '{4'b1111, 1'b1, 34'h0_0000_0019, 4'b0000, 4'b0000},
      '{4'b1111, 1'b1, 34'h0_0000_001A, 4'b0001, 4'b0001},
      '{4'b1111, 1'b1, 34'h0_0000_001B, 4'b0000, 4'b0000},
      '{4'b1111, 1'b1, 34'h0_0000_001C, 4'b0010, 4'b0010},
      '{4'b1001, 1'b0, 34'h2_0000_0000, 4'b0000, 4'b0000},
      '{4'b1001, 1'b1, 34'h2_0000_0001, 4'b1000, 4'b1000},
      '{4'b1001, 1'b0, 34'h2_0000_0002, 4'b0000, 4'b0000},
      '{4'b1001, 1'b1, 34'h2_0000_0003, 4'b0001, 4'b0001},
      '{4'b0100, 1'b0, 34'h0_1234_5678, 4'b0000, 4'b0000},
      '{4'b0100, 1'b0, 34'h0_1234_5679, 4'b0100, 4'b0000},
      '{4'b0100, 1'b1, 34'h1_DEAD_BEEF, 4'b0100, 4'b0100},
      '{4'b0000, 1'b0, 34'h0_0000_0000, 4'b0000, 4'b0000},
      '{4'b0000, 1'b1, 34'h3_FFFF_FFFF, 4'b0000, 4'b0000},
      '{4'b0000, 1'b0, 34'h0_0000_0001, 4'b0000, 4'b0000}
    };
    bus.i_request_valid = 4'b1111;
    bus.i_ready         = 1'b1;
    bus.i_response      = '0;
    for (int i = 0; i < 4; i++) bus.i_request_payload[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
    #7;
    chk_out("reset", 4'b0000, 4'b0000);
    bus.i_request_valid = '0;
    bus.i_ready         = 1'b0;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 22; k++) begin
      cyc(tbl[k].valid, tbl[k].ready, tbl[k].resp);
      chk_out($sformatf("row%0d", k), tbl[k].grant, tbl[k].rr);
      check($sformatf("row%0d response", k), 64'(bus.o_response), 64'(tbl[k].resp));
    end
    // requester 1 holds the port for 10 cycles while requester 3 joins mid-way
    cyc(4'b0010, 1'b0, '0);
    chk_out("long start", 4'b0000, 4'b0000);
    for (int t = 0; t < 10; t++) begin
      cyc(t >= 5 ? 4'b1010 : 4'b0010, 1'b0, '0);
      chk_out($sformatf("long hold%0d", t), 4'b0010, 4'b0000);
    end
    cyc(4'b1010, 1'b1, 34'h0_0BAD_F00D);
    chk_out("long done", 4'b0010, 4'b0010);
    cyc(4'b1010, 1'b0, '0);
    chk_out("long idle", 4'b0000, 4'b0000);
    cyc(4'b1000, 1'b0, '0);
    chk_out("req3 won", 4'b1000, 4'b0000);
    bus.i_ready = 1'b1;
    #1;
    chk_out("pre-reset ready", 4'b1000, 4'b1000);
    rst_n = 1'b0;
    #1;
    chk_out("async reset", 4'b0000, 4'b0000);
    bus.i_request_valid = 4'b1111;
    bus.i_ready         = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_out("post-reset grant", 4'b0001, 4'b0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rggen_rr_arbiter.md
# rggen_rr_arbiter

Round-robin arbiter that shares one downstream register-access port among `REQUESTERS` upstream requesters. It registers a one-hot grant, uses that grant as the select of an internal one-hot AND-OR multiplexer to steer the winning requester's payload downstream, and routes the transaction-done handshake back to the winner. It sits between multiple bus-protocol front ends and a single register block, or any shared datapath that a one-hot select can drive.

## Interface

- `REQUESTERS`, default 2: number of upstream requesters; must be 1 or more.
- `PAYLOAD_WIDTH`, default 32: width of the request payload (address, command and write data, packed by the integrator).
- `RESPONSE_WIDTH`, default 34: width of the response payload (read data and status).
- `i_clk`  input  1  clock; one clock domain.
- `i_rst_n`  input  1  reset; asynchronous assert, active-low.
- `i_request_valid`  input  REQUESTERS  per-requester request valid.
- `i_request_payload`  input  REQUESTERS×PAYLOAD_WIDTH  packed per-requester payloads.
- `o_request_ready`  output  REQUESTERS  per-requester transaction-done strobe.
- `o_response`  output  RESPONSE_WIDTH  `i_response`, broadcast to all requesters.
- `o_grant`  output  REQUESTERS  registered one-hot grant; all zeros when idle.
- `o_valid`  output  1  downstream request valid.
- `o_payload`  output  PAYLOAD_WIDTH  downstream payload, selected from the inputs by `o_grant`.
- `i_ready`  input  1  downstream transaction done.
- `i_response`  input  RESPONSE_WIDTH  downstream response; valid when `i_ready`=1.

## Operation

- Two states:
  - IDLE: `o_grant`=0, `o_valid`=0.
  - BUSY: exactly one `o_grant` bit is set, `o_valid`=1.
- IDLE → BUSY: taken when any `i_request_valid` bit is 1.
  - The winner is the first requester with valid asserted, searching from index `last+1` upward and wrapping modulo REQUESTERS.
  - `last` is the index of the most recently completed grant.
  - The winner's one-hot grant is registered.
- BUSY → IDLE: taken when `i_ready`=1.
  - `o_grant` is cleared.
  - `last` is set to the granted index.
- `i_request_valid` is ignored while BUSY. The grant holds until `i_ready`, even if the granted requester drops valid. A requester dropping valid before ready is a protocol violation; it is not checked.
- `o_payload` is the bitwise OR over all `i` of (`{PAYLOAD_WIDTH{o_grant[i]}}` & `i_request_payload[i]`). It is therefore all zeros in IDLE.
- `o_request_ready[i]` = `o_grant[i]` & `i_ready`, combinational.
- `o_response` = `i_response`, combinational and unregistered. A requester qualifies it with its own `o_request_ready`.
- `i_ready` asserted in IDLE is ignored. It causes no state change and no `o_request_ready`.
- REQUESTERS=1:
  - The same state machine is used.
  - The grant is 1'b1 in BUSY.
  - The round-robin pointer is degenerate (constant 0).
- Reset values:
  - State = IDLE.
  - `o_grant` = 0, `o_valid` = 0, `o_payload` = 0, `o_request_ready` = 0.
  - `last` = REQUESTERS-1, so requester 0 has top priority on the first arbitration.

## Timing

- Arbitration latency: `i_request_valid` sampled high in IDLE at edge N gives `o_grant`/`o_valid` high from edge N, visible in cycle N+1.
- Transaction end: `i_ready`=1 during a BUSY cycle gives `o_request_ready` pulsing in that same cycle. `o_grant`/`o_valid` go low from the next edge.
- Back-to-back: after a completion the arbiter spends exactly one cycle in IDLE before the next grant. Minimum spacing between grants is therefore 2 cycles for 1-cycle downstream transactions.
- Simultaneous requests in one IDLE cycle: exactly one winner, per the round-robin order. Losers keep valid asserted and win in later rounds.
- Fairness: with all REQUESTERS continuously requesting, each requester is granted once per REQUESTERS grants, in ascending index order with wrap.
- Asynchronous reset asserted mid-BUSY:
  - `o_grant`, `o_valid` and `o_request_ready` go low immediately, without waiting for a clock edge.
  - No completion is reported to the interrupted requester.
  - `last` returns to REQUESTERS-1.

## Test plan

- Reset then single request: REQUESTERS=4, only `i_request_valid`=4'b0100 with payload[2]=32'hA5A5_0002.
  - One cycle later: `o_grant`=4'b0100, `o_valid`=1, `o_payload`=32'hA5A5_0002.
  - `i_ready` pulse: `o_request_ready`=4'b0100 in the same cycle, `o_grant`=0 on the next cycle.
- Round-robin with all four requesting continuously and `i_ready` high on every BUSY cycle:
  - Grant sequence after reset is 0,1,2,3,0,1.
  - Each grant is separated by one IDLE cycle.
- Skip non-requesters: `last`=1, `i_request_valid`=4'b1001.
  - Grant goes to 3; the next grant goes to 0.
- Long transaction with competition: `i_ready` held low 10 cycles while requester 1 is granted, and requester 3 asserts valid mid-way.
  - `o_grant` stays 4'b0010 for all 10 cycles; `o_request_ready`=0 throughout.
  - Requester 3 is granted after completion.
- Spurious ready and response fan-out:
  - `i_ready`=1 in IDLE gives no `o_request_ready` and no state change.
  - `i_response`=34'h1_DEAD_BEEF during a completion of requester 2: `o_response` equals it, `o_request_ready`=4'b0100.
- Reset mid-BUSY: `i_rst_n` dropped while `o_grant`=4'b1000.
  - Outputs are zero asynchronously.
  - After release, with 4'b1111 requesting, the first grant goes to requester 0.
